// File: rtl/aes_req_arbiter_pkg.sv
// aes_arb_pkg: shared types and constants for the AES request arbiter.
package aes_arb_pkg;
    localparam int AES_BLK_W = 128;
    typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_e;
    typedef struct packed {
        logic [AES_BLK_W-1:0] key;
        logic [AES_BLK_W-1:0] text;
    } aes_req_t;
endpackage

// File: rtl/aes_req_arbiter_if.sv
// aes_req_arbiter_if: request channels and tagged response channel of the AES arbiter.
interface aes_req_arbiter_if #(parameter int NUM_REQ = 4);
    import aes_arb_pkg::*;
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*AES_BLK_W-1:0] req_key;
    logic [NUM_REQ*AES_BLK_W-1:0] req_text;
    logic                         resp_valid;
    logic                         resp_ready;
    logic [ID_W-1:0]              resp_id;
    logic [AES_BLK_W-1:0]         resp_data;
    logic                         resp_timeout;
    modport master (
        output req_valid, req_key, req_text, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_timeout
    );
    modport slave (
        input  req_valid, req_key, req_text, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_timeout
    );
endinterface

// File: rtl/aes_req_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker starting one past last_grant.
module rr_grant #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    // Scan farthest-first so the nearest requester after last overwrites.
    always_comb begin
        idx = '0;
        for (int k = N; k >= 1; k--)
            if (req[(int'(last) + k) % N]) idx = IW'((int'(last) + k) % N);
    end
    assign any = |req;
    assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: round-robin sharing of one AES-128 core with a done watchdog.
module aes_req_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_req_arbiter_if.slave     bus,
    output logic                 core_ld,
    output logic [AES_BLK_W-1:0] core_key,
    output logic [AES_BLK_W-1:0] core_text_in,
    input  logic                 core_done,
    input  logic [AES_BLK_W-1:0] core_text_out,
    output logic                 err_stray_done
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    state_e               state_q, state_d;
    logic [ID_W-1:0]      last_q, last_d, id_q, id_d, gnt_idx;
    aes_req_t             job_q, job_d;
    logic [AES_BLK_W-1:0] data_q, data_d;
    logic                 tout_q, tout_d, stray_q, stray_d, gnt_any;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_REQ-1:0]   gnt;

    rr_grant #(.N(NUM_REQ)) u_rr (
        .req  (bus.req_valid),
        .last (last_q),
        .gnt  (gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        job_d   = job_q;
        data_d  = data_q;
        tout_d  = tout_q;
        timer_d = timer_q;
        stray_d = stray_q | (core_done && state_q != BUSY);
        case (state_q)
            IDLE: if (gnt_any) begin
                job_d   = '{key:  bus.req_key[gnt_idx*AES_BLK_W +: AES_BLK_W],
                            text: bus.req_text[gnt_idx*AES_BLK_W +: AES_BLK_W]};
                id_d    = gnt_idx;
                state_d = LOAD;
            end
            LOAD: begin
                timer_d = '0;
                state_d = BUSY;
            end
            // done on the final watchdog cycle still counts as a completion
            BUSY: begin
                timer_d = timer_q + 1'b1;
                if (core_done) begin
                    data_d  = core_text_out;
                    tout_d  = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    data_d  = '0;
                    tout_d  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: if (bus.resp_ready) begin
                last_d  = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            job_q   <= '0;
            data_q  <= '0;
            tout_q  <= 1'b0;
            stray_q <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            job_q   <= job_d;
            data_q  <= data_d;
            tout_q  <= tout_d;
            stray_q <= stray_d;
            timer_q <= timer_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE) ? gnt : '0;
    assign bus.resp_valid   = state_q == RESP;
    assign bus.resp_id      = id_q;
    assign bus.resp_data    = data_q;
    assign bus.resp_timeout = tout_q;
    assign core_ld          = state_q == LOAD;
    assign core_key         = job_q.key;
    assign core_text_in     = job_q.text;
    assign err_stray_done   = stray_q;
endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: directed vector table plus corner sequences against a behavioural AES core.
module tb_aes_req_arbiter;
    import aes_arb_pkg::*;
    localparam int NR = 4, TO = 64, LAT = 10, NV = 14;
    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    aes_req_arbiter_if #(.NUM_REQ(NR)) bus();
    logic         core_ld, core_done, err_stray_done;
    logic [127:0] core_key, core_text_in, core_text_out;

    aes_req_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .core_ld        (core_ld),
        .core_key       (core_key),
        .core_text_in   (core_text_in),
        .core_done      (core_done),
        .core_text_out  (core_text_out),
        .err_stray_done (err_stray_done)
    );

    int checks = 0, errors = 0;
    logic [127:0] keys [NR];
    logic [127:0] texts [NR];
    logic [7:0]   sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    task automatic init_sbox;
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int u = 1; u < 256; u++)
                if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) b[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[b[i]];
            for (int i = 0; i < 16; i++) b[i] = t[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
                    t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
                for (int i = 0; i < 16; i++) b[i] = t[i];
            end
            for (int i = 0; i < 16; i++) b[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o;
    endfunction

    // Behavioural core: done LAT cycles after ld unless stubbed out.
    logic         stub = 1'b0, inj_done = 1'b0, model_done;
    logic [7:0]   cnt;
    logic [127:0] ct;
    always @(posedge clk) begin
        if (rst) cnt <= 8'd0;
        else if (core_ld) begin
            cnt <= 8'(LAT);
            ct  <= aes_enc(core_key, core_text_in);
        end else if (cnt != 8'd0) cnt <= cnt - 8'd1;
    end
    assign model_done    = (cnt == 8'd1) && !stub;
    assign core_done     = model_done | inj_done;
    assign core_text_out = model_done ? ct : '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 128'(bus.req_ready), 128'(4'b0000));
        chk({tag, "_resp_valid"}, 128'(bus.resp_valid), 128'(1'b0));
        chk({tag, "_resp_id"}, 128'(bus.resp_id), 128'(2'd0));
        chk({tag, "_resp_data"}, bus.resp_data, 128'h0);
        chk({tag, "_resp_timeout"}, 128'(bus.resp_timeout), 128'(1'b0));
        chk({tag, "_core_ld"}, 128'(core_ld), 128'(1'b0));
        chk({tag, "_core_key"}, core_key, 128'h0);
        chk({tag, "_core_text_in"}, core_text_in, 128'h0);
        chk({tag, "_err_stray_done"}, 128'(err_stray_done), 128'(1'b0));
    endtask

    task automatic wait_grant(output logic [3:0] g);
        int n;
        #1;
        n = 0;
        while (bus.req_ready == '0 && n < 20) begin
            tick;
            n++;
        end
        g = bus.req_ready;
    endtask

    task automatic run_job(input logic [3:0] mask, input int exp, output logic [127:0] data);
        int n;
        logic [3:0] g;
        logic quiet;
        bus.req_valid = mask;
        wait_grant(g);
        chk("grant", 128'(g), 128'(4'b0001 << exp));
        tick;
        bus.req_valid = mask & ~g;
        chk("core_ld", 128'(core_ld), 128'(1'b1));
        chk("core_key", core_key, keys[exp]);
        chk("core_text_in", core_text_in, texts[exp]);
        quiet = 1'b1;
        n = 0;
        while (!bus.resp_valid && n < 200) begin
            if (bus.req_ready != '0) quiet = 1'b0;
            tick;
            n++;
        end
        if (bus.req_ready != '0) quiet = 1'b0;
        chk("resp_wait", 128'(n < 200), 128'(1'b1));
        chk("resp_id", 128'(bus.resp_id), 128'(exp));
        chk("resp_data", bus.resp_data, aes_enc(keys[exp], texts[exp]));
        chk("resp_timeout", 128'(bus.resp_timeout), 128'(1'b0));
        data = bus.resp_data;
        bus.resp_ready = 1'b1;
        tick;
        bus.resp_ready = 1'b0;
        chk("ready_quiet", 128'(quiet), 128'(1'b1));
        chk("resp_drop", 128'(bus.resp_valid), 128'(1'b0));
    endtask

    typedef struct {
        logic       rst_first;
        logic [3:0] valid;
        int         exp_id;
    } vec_t;
    vec_t vecs [NV];

    initial begin
        #600000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] d, rd;
        logic [3:0]   g;
        logic [1:0]   rid;
        logic         rt, stable, quiet, seen;
        int           n;
        vecs[0]  = '{1'b1, 4'b0010, 1};
        vecs[1]  = '{1'b1, 4'b0101, 0};
        vecs[2]  = '{1'b0, 4'b0101, 2};
        vecs[3]  = '{1'b1, 4'b1111, 0};
        vecs[4]  = '{1'b0, 4'b1111, 1};
        vecs[5]  = '{1'b0, 4'b1111, 2};
        vecs[6]  = '{1'b0, 4'b1111, 3};
        vecs[7]  = '{1'b0, 4'b1111, 0};
        vecs[8]  = '{1'b0, 4'b1111, 1};
        vecs[9]  = '{1'b0, 4'b1111, 2};
        vecs[10] = '{1'b0, 4'b1111, 3};
        vecs[11] = '{1'b0, 4'b1001, 0};
        vecs[12] = '{1'b0, 4'b1100, 2};
        vecs[13] = '{1'b0, 4'b1000, 3};
        init_sbox;
        for (int i = 0; i < NR; i++) begin
            keys[i]  = FK ^ {32{4'(i ^ 1)}};
            texts[i] = FT ^ {32{4'(i ^ 1)}};
            bus.req_key[i*128 +: 128]  = keys[i];
            bus.req_text[i*128 +: 128] = texts[i];
        end
        do_reset;
        check_reset_outputs("reset");

        for (int v = 0; v < NV; v++) begin
            if (vecs[v].rst_first) do_reset;
            run_job(vecs[v].valid, vecs[v].exp_id, d);
            if (v == 0) chk("fips_ciphertext", d, FC);
        end
        bus.req_valid = '0;
        chk("no_stray_yet", 128'(err_stray_done), 128'(1'b0));

        // Watchdog: stubbed core never completes.
        stub = 1'b1;
        do_reset;
        bus.req_valid = 4'b0001;
        wait_grant(g);
        chk("to_grant", 128'(g), 128'(4'b0001));
        tick;
        bus.req_valid = '0;
        chk("to_core_ld", 128'(core_ld), 128'(1'b1));
        n = 0;
        tick;
        while (!bus.resp_valid && n < 200) begin
            n++;
            tick;
        end
        chk("to_busy_cycles", 128'(n), 128'(TO));
        chk("to_resp_timeout", 128'(bus.resp_timeout), 128'(1'b1));
        chk("to_resp_data", bus.resp_data, 128'h0);
        chk("to_resp_id", 128'(bus.resp_id), 128'(2'd0));
        bus.resp_ready = 1'b1;
        tick;
        bus.resp_ready = 1'b0;
        stub = 1'b0;
        run_job(4'b0010, 1, d);

        // Backpressure with a stray done injected in RESP.
        do_reset;
        bus.req_valid = 4'b0001;
        wait_grant(g);
        tick;
        bus.req_valid = 4'b1110;
        n = 0;
        while (!bus.resp_valid && n < 200) begin
            tick;
            n++;
        end
        chk("bp_resp_valid", 128'(bus.resp_valid), 128'(1'b1));
        rid = bus.resp_id;
        rd  = bus.resp_data;
        rt  = bus.resp_timeout;
        chk("bp_resp_data", rd, aes_enc(keys[0], texts[0]));
        chk("bp_stray_before", 128'(err_stray_done), 128'(1'b0));
        stable = 1'b1;
        quiet  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            inj_done = (c == 3);
            tick;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== rid || bus.resp_data !== rd || bus.resp_timeout !== rt)
                stable = 1'b0;
            if (bus.req_ready != '0) quiet = 1'b0;
        end
        inj_done = 1'b0;
        chk("bp_stable", 128'(stable), 128'(1'b1));
        chk("bp_no_ready", 128'(quiet), 128'(1'b1));
        chk("bp_stray_set", 128'(err_stray_done), 128'(1'b1));
        bus.resp_ready = 1'b1;
        tick;
        bus.resp_ready = 1'b0;
        run_job(4'b1110, 1, d);
        chk("stray_sticky", 128'(err_stray_done), 128'(1'b1));

        // Reset in the middle of BUSY abandons the job.
        bus.req_valid = 4'b0100;
        wait_grant(g);
        chk("mr_grant", 128'(g), 128'(4'b0100));
        tick;
        bus.req_valid = '0;
        chk("mr_core_ld", 128'(core_ld), 128'(1'b1));
        repeat (5) tick;
        rst = 1'b1;
        tick;
        check_reset_outputs("midreset");
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick;
            if (bus.resp_valid) seen = 1'b1;
        end
        chk("mr_no_response", 128'(seen), 128'(1'b0));
        run_job(4'b1111, 0, d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
